wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter between the VLIW execute slots and the register file write ports. Each cycle it accepts one bundle's worth of slot writeback requests, up to NSLOT. It queues them in order and drains them to the register file through NWP write ports, oldest first. It also publishes a pending-write mask so issue logic can stall on read-after-write hazards against queued results.

## Interface
- NSLOT, 10: execute slots per bundle
- NWP, 2: register file write ports
- DEPTH, 16: queue entries, power of two, ≥ NSLOT
- REG_W, 5: register address width (32 registers)
- DATA_W, 32: register data width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- bundle_valid  in  1  request vectors below are valid this cycle
- bundle_ready  out  1  arbiter can accept a full bundle this cycle
- req_valid  in  NSLOT  per-slot writeback request
- req_addr  in  NSLOT*REG_W  per-slot destination register, slot s at bits [s*REG_W +: REG_W]
- req_data  in  NSLOT*DATA_W  per-slot result
- wr_en  out  NWP  per-port write strobe
- wr_addr  out  NWP*REG_W  per-port register address
- wr_data  out  NWP*DATA_W  per-port data
- pend_mask  out  32  bit r is set while any queued entry targets register r
- busy  out  1  queue non-empty

## Operation
- **Accept.** A bundle is accepted on an edge when bundle_valid && bundle_ready.
  - bundle_ready = (DEPTH − count ≥ NSLOT) && !rst.
  - bundle_ready is conservative: it does not depend on how many req_valid bits are set.
- **Enqueue.** Valid slots are enqueued in ascending slot order at tail, tail+1, and so on.
  - Pointers wrap modulo DEPTH.
  - The number enqueued equals the popcount of the effective valid bits.
- **Intra-bundle duplicates.** When two or more valid slots name the same register, only the highest-index slot is enqueued. Lower-index duplicates are dropped.
- **Register 0.** r0 is treated like any other register.
- **Drain.** Each cycle, port k (k = 0..NWP−1) presents entry head+k when all of the following hold:
  - the entry exists (k < count);
  - ports 0..k−1 are also presenting;
  - its address differs from the addresses on ports 0..k−1.
  - The first failing port and all higher ports are idle. This keeps per-register write order.
- **Dequeue.** Presented entries are dequeued on the edge, and head advances by the number presented.
- **Simultaneous events.** Enqueue and dequeue in the same cycle are allowed: count_next = count + n_enq − n_deq.
- **Outputs.** pend_mask and busy are combinational from queue state. They include entries being presented this cycle.
- **Reset.** On rst, all queue state is discarded and no writes are issued. This also applies mid-operation.

## Timing
- **Reset values.** While rst is high and on the cycle after release:
  - wr_en = 0, pend_mask = 0, busy = 0, count = 0;
  - bundle_ready = 0 while rst is high and 1 after release.
- **Latency.** A bundle accepted at edge E can appear on wr_* in the cycle after E and is written at edge E+1 at the earliest. There is no zero-cycle bypass.
- **Output decode.** wr_* are combinational from head entries. The register file samples them on the same edge that dequeues them.
- **Drain rate.** Peak drain is NWP entries per cycle. A full 10-slot bundle drains in 5 cycles when all addresses are distinct.
- **pend_mask clearing.** Bit r clears on the edge that dequeues the last queued entry for r.
- **Full.** When fewer than NSLOT entries are free, bundle_ready is low. bundle_valid is ignored and the requester must hold.
- **Empty.** When count is 0, wr_en = 0.

## Structure
- Shared package vliw_pkg holds:
  - NSLOT, REG_W and DATA_W constants;
  - the wb_entry_t struct {addr, data};
  - the register count (32).
- Sub-module wb_queue: a circular buffer with multi-push (≤NSLOT) and multi-pop (≤NWP), head/tail/count, and entry read-out.
- The dedup, drain-conflict and pend_mask logic live in wb_arbiter.

## Test plan
- **Reset.** Hold rst 2 cycles with bundle_valid = 1 → wr_en = 0, pend_mask = 0, bundle_ready = 0. After release, bundle_ready = 1 and busy = 0.
- **Back-to-back bundles.** Bundle A: slot 7 r5 = 451. Next cycle, bundle B: slot 7 r3 = 543.
  - Cycle after A: port 0 writes r5 = 451 and pend_mask = 0x20.
  - Next cycle: port 0 writes r3 = 543.
  - Then busy = 0.
- **Intra-bundle duplicate.** Slots 2 and 6 both target r7, with data 10 and 20 → exactly one write, r7 = 20. The queue holds 1 entry.
- **Cross-bundle conflict.** Bundle 1: slot 0 r4 = 1. Bundle 2: slot 0 r4 = 2 and slot 1 r9 = 3.
  - First: port 0 writes r4 = 1 and port 1 is idle.
  - Next cycle: r4 = 2 on port 0 and r9 = 3 on port 1.
- **Full.** Two 10-slot bundles with distinct registers, offered on consecutive cycles.
  - First accepted at E0; bundle_ready is low for the cycles after E0 and E1.
  - Second accepted in the cycle after E2, when count = 6.
  - All 20 writes appear in slot order.
- **Reset mid-operation.** With 8 entries queued, assert rst for 1 cycle → wr_en = 0 from the next cycle, pend_mask = 0, and no further writes reach the register file.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared VLIW constants and the writeback entry type.
// Used by the writeback arbiter, its queue and its interface.
package vliw_pkg;

    localparam int NSLOT  = 10;
    localparam int NWP    = 2;
    localparam int DEPTH  = 16;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(NWP + 1);

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle request / register-file write bus of the writeback arbiter.
// master drives bundles and consumes writes; slave is the arbiter.
interface wb_arbiter_if;
    import vliw_pkg::*;

    logic                    bundle_valid;
    logic                    bundle_ready;
    logic [NSLOT-1:0]        req_valid;
    logic [NSLOT*REG_W-1:0]  req_addr;
    logic [NSLOT*DATA_W-1:0] req_data;
    logic [NWP-1:0]          wr_en;
    logic [NWP*REG_W-1:0]    wr_addr;
    logic [NWP*DATA_W-1:0]   wr_data;
    logic [NREG-1:0]         pend_mask;
    logic                    busy;

    modport master (
        output bundle_valid, req_valid, req_addr, req_data,
        input  bundle_ready, wr_en, wr_addr, wr_data,
        input  pend_mask, busy
    );

    modport slave (
        input  bundle_valid, req_valid, req_addr, req_data,
        output bundle_ready, wr_en, wr_addr, wr_data,
        output pend_mask, busy
    );

endinterface

// File: rtl/wb_arbiter_queue.sv
// Circular writeback buffer: multi-push at tail, multi-pop at head.
// Exposes head entries, raw storage and an occupancy map.
module wb_queue
    import vliw_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NSLOT-1:0] push_en,
    input  wb_entry_t        push_ent [NSLOT],
    input  logic [NW-1:0]    pop_n,
    output wb_entry_t        head_ent [NWP],
    output wb_entry_t        ent      [DEPTH],
    output logic [DEPTH-1:0] occ,
    output logic [CW-1:0]    count
);

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    idx [NSLOT];
    logic [CW-1:0]    n_push;
    logic [PW-1:0]    d;

    // Valid slots pack densely from tail in ascending slot order.
    always_comb begin
        n_push = '0;
        for (int s = 0; s < NSLOT; s++) begin
            idx[s] = tail + n_push[PW-1:0];
            if (push_en[s])
                n_push = n_push + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NSLOT; s++)
            if (push_en[s])
                mem[idx[s]] <= push_ent[s];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + n_push[PW-1:0];
            count <= count + n_push - CW'(pop_n);
        end
    end

    always_comb begin
        d = '0;
        for (int k = 0; k < NWP; k++)
            head_ent[k] = mem[head + PW'(k)];
        for (int i = 0; i < DEPTH; i++) begin
            d      = PW'(i) - head;
            occ[i] = {1'b0, d} < count;
        end
    end

    assign ent = mem;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: dedups slot results, queues them in order and
// drains up to NWP per cycle while keeping per-register write order.
module wb_arbiter
    import vliw_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_entry_t        push_ent [NSLOT];
    wb_entry_t        head_ent [NWP];
    wb_entry_t        ent      [DEPTH];
    logic [NSLOT-1:0] eff;
    logic [NSLOT-1:0] push_en;
    logic [DEPTH-1:0] occ;
    logic [CW-1:0]    count;
    logic [NW-1:0]    pop_n;
    logic [NWP-1:0]   pres;
    logic [NREG-1:0]  pend;
    logic             accept;
    logic             run;

    wb_queue u_queue (
        .clk      (clk),
        .rst      (rst),
        .push_en  (push_en),
        .push_ent (push_ent),
        .pop_n    (pop_n),
        .head_ent (head_ent),
        .ent      (ent),
        .occ      (occ),
        .count    (count)
    );

    assign bus.bundle_ready = !rst && (count <= CW'(DEPTH - NSLOT));
    assign accept           = bus.bundle_valid && bus.bundle_ready;
    assign push_en          = accept ? eff : '0;

    // A later slot naming the same register supersedes earlier ones.
    always_comb begin
        eff = '0;
        for (int s = 0; s < NSLOT; s++) begin
            push_ent[s] = '{addr: bus.req_addr[s*REG_W +: REG_W],
                            data: bus.req_data[s*DATA_W +: DATA_W]};
            eff[s] = bus.req_valid[s];
            for (int t = s + 1; t < NSLOT; t++)
                if (bus.req_valid[t] &&
                    bus.req_addr[t*REG_W +: REG_W] ==
                    bus.req_addr[s*REG_W +: REG_W])
                    eff[s] = 1'b0;
        end
    end

    // Ports fill in order; stop at the first missing or clashing entry.
    always_comb begin
        pres  = '0;
        pop_n = '0;
        run   = !rst;
        for (int k = 0; k < NWP; k++) begin
            if (CW'(k) >= count)
                run = 1'b0;
            for (int j = 0; j < k; j++)
                if (head_ent[j].addr == head_ent[k].addr)
                    run = 1'b0;
            pres[k] = run;
            if (run)
                pop_n = pop_n + 1'b1;
        end
    end

    always_comb begin
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int k = 0; k < NWP; k++) begin
            bus.wr_addr[k*REG_W +: REG_W]   = head_ent[k].addr;
            bus.wr_data[k*DATA_W +: DATA_W] = head_ent[k].data;
        end
    end

    always_comb begin
        pend = '0;
        if (!rst)
            for (int i = 0; i < DEPTH; i++)
                if (occ[i])
                    pend[ent[i].addr] = 1'b1;
    end

    assign bus.wr_en     = pres;
    assign bus.pend_mask = pend;
    assign bus.busy      = !rst && (count != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_arbiter;
    import vliw_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    wb_entry_t mq[$];

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1);
    end

    // Reference model: entries a port may take this cycle.
    function automatic int mdl_npres();
        int n = 0;
        for (int k = 0; k < NWP && k < mq.size(); k++) begin
            bit clash = 0;
            for (int j = 0; j < k; j++)
                if (mq[j].addr == mq[k].addr)
                    clash = 1;
            if (clash)
                break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [NREG-1:0] mdl_pend();
        logic [NREG-1:0] m = '0;
        foreach (mq[i])
            m[mq[i].addr] = 1'b1;
        return m;
    endfunction

    task automatic mdl_edge();
        int        np;
        bit        acc;
        bit        sup;
        wb_entry_t e;
        acc = bus.bundle_valid && !rst && (mq.size() <= DEPTH - NSLOT);
        if (rst) begin
            mq.delete();
            return;
        end
        np = mdl_npres();
        repeat (np)
            void'(mq.pop_front());
        if (acc)
            for (int s = 0; s < NSLOT; s++) begin
                sup = 0;
                for (int t = s + 1; t < NSLOT; t++)
                    if (bus.req_valid[t] && bus.req_valid[s] &&
                        bus.req_addr[t*REG_W +: REG_W] ==
                        bus.req_addr[s*REG_W +: REG_W])
                        sup = 1;
                if (bus.req_valid[s] && !sup) begin
                    e.addr = bus.req_addr[s*REG_W +: REG_W];
                    e.data = bus.req_data[s*DATA_W +: DATA_W];
                    mq.push_back(e);
                end
            end
    endtask

    task automatic adv();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic clr();
        bus.bundle_valid = 1'b0;
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
    endtask

    task automatic set_slot(input int s, input int a, input int d);
        bus.req_valid[s]                = 1'b1;
        bus.req_addr[s*REG_W +: REG_W]   = REG_W'(a);
        bus.req_data[s*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        bus.bundle_valid = 1'b1;
        set_slot(0, 3, 7);
        repeat (2) begin
            @(negedge clk);
            nvec++;
            if (bus.wr_en !== '0) begin
                nerr++;
                $display("FAIL reset_wr_en: got %0h want 0", bus.wr_en);
            end
            nvec++;
            if (bus.pend_mask !== '0) begin
                nerr++;
                $display("FAIL reset_pend: got %0h want 0", bus.pend_mask);
            end
            nvec++;
            if (bus.bundle_ready !== 1'b0) begin
                nerr++;
                $display("FAIL reset_ready: got %b want 0", bus.bundle_ready);
            end
            adv();
        end
        rst = 1'b0;
        clr();
        @(negedge clk);
        nvec++;
        if ({bus.bundle_ready, bus.busy, bus.wr_en} !== {1'b1, 1'b0, 2'b00}) begin
            nerr++;
            $display("FAIL release: got rdy=%b busy=%b en=%b want 1 0 00",
                     bus.bundle_ready, bus.busy, bus.wr_en);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        clr();
        bus.bundle_valid = 1'b1;
        set_slot(7, 5, 451);
        @(negedge clk);
        nvec++;
        if (bus.bundle_ready !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_ready: got %b want 1", bus.bundle_ready);
        end
        adv();
        clr();
        bus.bundle_valid = 1'b1;
        set_slot(7, 3, 543);
        @(negedge clk);
        nvec++;
        if ({bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0]} !==
            {2'b01, 5'd5, 32'd451}) begin
            nerr++;
            $display("FAIL b2b_a: got en=%b r%0d=%0d want en=01 r5=451",
                     bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0]);
        end
        nvec++;
        if (bus.pend_mask !== 32'h20) begin
            nerr++;
            $display("FAIL b2b_pend: got %h want 00000020", bus.pend_mask);
        end
        adv();
        clr();
        @(negedge clk);
        nvec++;
        if ({bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0]} !==
            {2'b01, 5'd3, 32'd543}) begin
            nerr++;
            $display("FAIL b2b_b: got en=%b r%0d=%0d want en=01 r3=543",
                     bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0]);
        end
        adv();
        @(negedge clk);
        nvec++;
        if ({bus.busy, bus.wr_en} !== 3'b000) begin
            nerr++;
            $display("FAIL b2b_idle: got busy=%b en=%b want 0 00",
                     bus.busy, bus.wr_en);
        end
        adv();
    endtask

    task automatic test_dup();
        clr();
        bus.bundle_valid = 1'b1;
        set_slot(2, 7, 10);
        set_slot(6, 7, 20);
        adv();
        clr();
        @(negedge clk);
        nvec++;
        if ({bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0],
             bus.pend_mask} !== {2'b01, 5'd7, 32'd20, 32'h80}) begin
            nerr++;
            $display("FAIL dup_write: got en=%b r%0d=%0d pend=%h want 01 r7=20 80",
                     bus.wr_en, bus.wr_addr[REG_W-1:0],
                     bus.wr_data[DATA_W-1:0], bus.pend_mask);
        end
        adv();
        @(negedge clk);
        nvec++;
        if ({bus.busy, bus.wr_en} !== 3'b000) begin
            nerr++;
            $display("FAIL dup_single: got busy=%b en=%b want 0 00",
                     bus.busy, bus.wr_en);
        end
        adv();
    endtask

    task automatic test_conflict();
        clr();
        bus.bundle_valid = 1'b1;
        set_slot(0, 4, 1);
        adv();
        clr();
        bus.bundle_valid = 1'b1;
        set_slot(0, 4, 2);
        set_slot(1, 9, 3);
        @(negedge clk);
        nvec++;
        if ({bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0]} !==
            {2'b01, 5'd4, 32'd1}) begin
            nerr++;
            $display("FAIL conflict_first: got en=%b r%0d=%0d want 01 r4=1",
                     bus.wr_en, bus.wr_addr[REG_W-1:0], bus.wr_data[DATA_W-1:0]);
        end
        adv();
        clr();
        @(negedge clk);
        nvec++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !==
            {2'b11, 5'd9, 5'd4, 32'd3, 32'd2}) begin
            nerr++;
            $display("FAIL conflict_pair: got en=%b addr=%h data=%h want 11 r4=2 r9=3",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        adv();
        @(negedge clk);
        nvec++;
        if (bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL conflict_idle: got busy=%b want 0", bus.busy);
        end
        adv();
    endtask

    task automatic test_full();
        wb_entry_t exp_q[$];
        wb_entry_t got[$];
        wb_entry_t e;
        bit        done = 0;
        logic      want_rdy [3] = '{1'b0, 1'b0, 1'b1};
        clr();
        bus.bundle_valid = 1'b1;
        for (int s = 0; s < NSLOT; s++) begin
            e.addr = REG_W'(s + 1);
            e.data = $urandom;
            exp_q.push_back(e);
            set_slot(s, s + 1, int'(e.data));
        end
        @(negedge clk);
        nvec++;
        if (bus.bundle_ready !== 1'b1) begin
            nerr++;
            $display("FAIL full_ready0: got %b want 1", bus.bundle_ready);
        end
        adv();
        clr();
        bus.bundle_valid = 1'b1;
        for (int s = 0; s < NSLOT; s++) begin
            e.addr = REG_W'(s + 11);
            e.data = $urandom;
            exp_q.push_back(e);
            set_slot(s, s + 11, int'(e.data));
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nvec++;
            if (bus.bundle_ready !== want_rdy[c]) begin
                nerr++;
                $display("FAIL full_ready_c%0d: got %b want %b",
                         c + 1, bus.bundle_ready, want_rdy[c]);
            end
            for (int k = 0; k < NWP; k++)
                if (bus.wr_en[k]) begin
                    e.addr = bus.wr_addr[k*REG_W +: REG_W];
                    e.data = bus.wr_data[k*DATA_W +: DATA_W];
                    got.push_back(e);
                end
            adv();
        end
        clr();
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (!bus.busy)
                done = 1;
            for (int k = 0; k < NWP; k++)
                if (bus.wr_en[k]) begin
                    e.addr = bus.wr_addr[k*REG_W +: REG_W];
                    e.data = bus.wr_data[k*DATA_W +: DATA_W];
                    got.push_back(e);
                end
            adv();
        end
        nvec++;
        if (!done || got.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL full_count: got %0d writes drained=%0b want 20 drained=1",
                     got.size(), done);
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            nvec++;
            if (got[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL full_order_%0d: got r%0d=%h want r%0d=%h",
                         i, got[i].addr, got[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        clr();
        bus.bundle_valid = 1'b1;
        for (int s = 0; s < 8; s++)
            set_slot(s, s + 2, int'($urandom));
        adv();
        clr();
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if ({bus.wr_en, bus.pend_mask} !== '0) begin
            nerr++;
            $display("FAIL rstmid_hold: got en=%b pend=%h want 0 0",
                     bus.wr_en, bus.pend_mask);
        end
        adv();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            nvec++;
            if ({bus.wr_en, bus.busy, bus.pend_mask} !== '0) begin
                nerr++;
                $display("FAIL rstmid_after: got en=%b busy=%b pend=%h want 0 0 0",
                         bus.wr_en, bus.busy, bus.pend_mask);
            end
            adv();
        end
    endtask

    task automatic test_random();
        int             np;
        bit             narrow;
        logic [NWP-1:0] ee;
        logic [NREG-1:0] ep;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.bundle_valid = ($urandom_range(0, 2) != 0);
            narrow = 1'($urandom_range(0, 1));
            for (int s = 0; s < NSLOT; s++) begin
                bus.req_valid[s] = 1'($urandom_range(0, 1));
                bus.req_addr[s*REG_W +: REG_W] =
                    REG_W'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
                bus.req_data[s*DATA_W +: DATA_W] = $urandom;
            end
            @(negedge clk);
            np = rst ? 0 : mdl_npres();
            ee = '0;
            for (int k = 0; k < np; k++)
                ee[k] = 1'b1;
            ep = rst ? '0 : mdl_pend();
            nvec++;
            if (bus.bundle_ready !== (!rst && mq.size() <= DEPTH - NSLOT)) begin
                nerr++;
                $display("FAIL rnd_ready_c%0d: got %b want %b", c,
                         bus.bundle_ready, !rst && mq.size() <= DEPTH - NSLOT);
            end
            nvec++;
            if (bus.busy !== (!rst && mq.size() != 0)) begin
                nerr++;
                $display("FAIL rnd_busy_c%0d: got %b want %b", c,
                         bus.busy, !rst && mq.size() != 0);
            end
            nvec++;
            if (bus.pend_mask !== ep) begin
                nerr++;
                $display("FAIL rnd_pend_c%0d: got %h want %h", c, bus.pend_mask, ep);
            end
            nvec++;
            if (bus.wr_en !== ee) begin
                nerr++;
                $display("FAIL rnd_wren_c%0d: got %b want %b", c, bus.wr_en, ee);
            end
            for (int k = 0; k < np; k++) begin
                nvec++;
                if ({bus.wr_addr[k*REG_W +: REG_W], bus.wr_data[k*DATA_W +: DATA_W]}
                    !== {mq[k].addr, mq[k].data}) begin
                    nerr++;
                    $display("FAIL rnd_port%0d_c%0d: got r%0d=%h want r%0d=%h", k, c,
                             bus.wr_addr[k*REG_W +: REG_W],
                             bus.wr_data[k*DATA_W +: DATA_W], mq[k].addr, mq[k].data);
                end
            end
            adv();
        end
        rst = 1'b0;
        clr();
        repeat (12)
            adv();
        @(negedge clk);
        nvec++;
        if (bus.busy !== 1'b0 || mq.size() != 0) begin
            nerr++;
            $display("FAIL rnd_drain: got busy=%b model=%0d want 0 0",
                     bus.busy, mq.size());
        end
        adv();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        test_reset();
        test_back_to_back();
        test_dup();
        test_conflict();
        test_full();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
